// File: rtl/ifmap_stream_framer.sv
// ifmap_stream_framer: buffers raw ifmap words in a small FIFO and frames them
// into rows of row_len words (num_rows rows), optionally followed by a zero
// "flush" row of flush_len words. Each output word carries a 2-bit tag:
// 10 = first word of a row, 01 = last, 11 = single-word row, 00 = middle.
//
// Ports
//   clk, reset            : rising-edge clock, async active-low reset
//   start, abort          : frame start pulse (latches config) / sync cancel
//   row_len, num_rows,
//   flush_len             : frame configuration
//   in_data/in_valid/
//   in_ready              : raw word input (in_ready = FIFO not full)
//   out_data/out_wen/
//   out_ready             : registered {tag, word} stream toward IFmap buffer
//   busy, done, err       : frame in progress / end pulse / sticky bad config
module ifmap_stream_framer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [LEN_WIDTH-1:0]    row_len,
  input  logic [LEN_WIDTH-1:0]    num_rows,
  input  logic [LEN_WIDTH-1:0]    flush_len,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH+1:0]   out_data,
  output logic                    out_wen,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OUT_W = DATA_WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_ROW, S_FLUSH, S_END} state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_count_next;
  logic                  r_in_ready;

  logic [LEN_WIDTH-1:0]  r_row_len;
  logic [LEN_WIDTH-1:0]  r_num_rows;
  logic [LEN_WIDTH-1:0]  r_flush_len;
  logic [LEN_WIDTH-1:0]  r_word_cnt;
  logic [LEN_WIDTH-1:0]  r_row_cnt;
  logic                  r_phase_done;

  logic [OUT_W-1:0]      r_out_data;
  logic                  r_out_wen;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_clear;
  logic                  w_cfg_load;
  logic                  w_cfg_ok;
  logic                  w_fifo_empty;
  logic                  w_slot_free;
  logic [LEN_WIDTH-1:0]  w_next_word;
  logic [LEN_WIDTH-1:0]  w_next_row;
  logic                  w_next_phase_done;
  logic                  w_next_wen;
  logic [OUT_W-1:0]      w_next_data;
  logic                  w_next_err;

  // Tag for word w of a row holding len words.
  function automatic logic [1:0] f_tag(input logic [LEN_WIDTH-1:0] w,
                                       input logic [LEN_WIDTH-1:0] len);
    if (len == LEN_WIDTH'(1))                 return 2'b11;
    else if (w == '0)                         return 2'b10;
    else if (w == len - LEN_WIDTH'(1))        return 2'b01;
    else                                      return 2'b00;
  endfunction

  assign w_push       = in_valid & r_in_ready;
  assign w_fifo_empty = (r_count == '0);
  assign w_slot_free  = ~r_out_wen | out_ready;
  assign w_cfg_ok     = (row_len != '0) && (num_rows != '0);
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // FIFO storage; pointers reset/clear on their own, so data needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  // FIFO pointers, occupancy and registered not-full flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else if (w_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next != CNT_W'(FIFO_DEPTH));
    end
  end

  // State, counters, output stage and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_row_len    <= '0;
      r_num_rows   <= '0;
      r_flush_len  <= '0;
      r_word_cnt   <= '0;
      r_row_cnt    <= '0;
      r_phase_done <= 1'b0;
      r_out_wen    <= 1'b0;
      r_out_data   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      if (w_cfg_load) begin
        r_row_len   <= row_len;
        r_num_rows  <= num_rows;
        r_flush_len <= flush_len;
      end
      r_word_cnt   <= w_next_word;
      r_row_cnt    <= w_next_row;
      r_phase_done <= w_next_phase_done;
      r_out_wen    <= w_next_wen;
      r_out_data   <= w_next_data;
      r_busy       <= (w_next_state != S_IDLE);
      r_done       <= (w_next_state == S_END);
      r_err        <= w_next_err;
    end
  end

  // Next-state and output-stage logic. Counters index the next word to load;
  // r_phase_done marks that the last word of the current phase is loaded, so
  // the phase ends when that word leaves the output register.
  always_comb begin
    w_next_state      = r_state;
    w_next_word       = r_word_cnt;
    w_next_row        = r_row_cnt;
    w_next_phase_done = r_phase_done;
    w_next_wen        = r_out_wen & ~out_ready;
    w_next_data       = r_out_data;
    w_next_err        = r_err;
    w_pop             = 1'b0;
    w_clear           = 1'b0;
    w_cfg_load        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_word       = '0;
          w_next_row        = '0;
          w_next_phase_done = 1'b0;
          if (w_cfg_ok) begin
            w_next_state = S_ROW;
            w_next_err   = 1'b0;
            w_cfg_load   = 1'b1;
          end else begin
            w_next_state = S_END;
            w_next_err   = 1'b1;
          end
        end
      end

      S_ROW: begin
        if (w_slot_free) begin
          if (r_phase_done) begin
            // Last row word is leaving; preload the first flush word so the
            // stream continues without a bubble.
            if (r_flush_len != '0) begin
              w_next_state = S_FLUSH;
              w_next_wen   = 1'b1;
              w_next_data  = {f_tag('0, r_flush_len), DATA_WIDTH'(0)};
              if (r_flush_len == LEN_WIDTH'(1)) begin
                w_next_word       = '0;
                w_next_phase_done = 1'b1;
              end else begin
                w_next_word       = LEN_WIDTH'(1);
                w_next_phase_done = 1'b0;
              end
            end else begin
              w_next_state = S_END;
            end
          end else if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_next_wen  = 1'b1;
            w_next_data = {f_tag(r_word_cnt, r_row_len), r_mem[r_rd_ptr]};
            if (r_word_cnt == r_row_len - LEN_WIDTH'(1)) begin
              w_next_word = '0;
              if (r_row_cnt == r_num_rows - LEN_WIDTH'(1)) begin
                w_next_phase_done = 1'b1;
              end else begin
                w_next_row = r_row_cnt + LEN_WIDTH'(1);
              end
            end else begin
              w_next_word = r_word_cnt + LEN_WIDTH'(1);
            end
          end
        end
      end

      S_FLUSH: begin
        if (w_slot_free) begin
          if (r_phase_done) begin
            w_next_state = S_END;
          end else begin
            w_next_wen  = 1'b1;
            w_next_data = {f_tag(r_word_cnt, r_flush_len), DATA_WIDTH'(0)};
            if (r_word_cnt == r_flush_len - LEN_WIDTH'(1)) begin
              w_next_phase_done = 1'b1;
            end else begin
              w_next_word = r_word_cnt + LEN_WIDTH'(1);
            end
          end
        end
      end

      S_END: begin
        w_next_state = S_IDLE;
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a same-cycle start.
    if (abort) begin
      w_next_state      = S_IDLE;
      w_next_word       = '0;
      w_next_row        = '0;
      w_next_phase_done = 1'b0;
      w_next_wen        = 1'b0;
      w_next_err        = r_err;
      w_pop             = 1'b0;
      w_clear           = 1'b1;
      w_cfg_load        = 1'b0;
    end
  end

  assign in_ready = r_in_ready;
  assign out_data = r_out_data;
  assign out_wen  = r_out_wen;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_ifmap_stream_framer.sv
// Randomized self-checking bench for ifmap_stream_framer. A reference model
// derives each expected output word from its position in the frame and the
// queue of words the DUT accepted.
module tb_ifmap_stream_framer;

  localparam int unsigned DW = 16;
  localparam int unsigned LW = 8;
  localparam int unsigned FD = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [LW-1:0] row_len;
  logic [LW-1:0] num_rows;
  logic [LW-1:0] flush_len;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW+1:0] out_data;
  logic          out_wen;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          err;

  ifmap_stream_framer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .row_len(row_len), .num_rows(num_rows), .flush_len(flush_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_wen(out_wen), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] acc_q[$];   // words the DUT accepted, not yet output
  logic [DW-1:0] tx_q[$];    // words still to be offered on the input
  int            m_L, m_R, m_F, m_k;
  int            done_cnt, wen_cnt;
  bit            stalled;
  logic [DW+1:0] stall_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_tag(input int w, input int len);
    if (len == 1)           return 2'b11;
    else if (w == 0)        return 2'b10;
    else if (w == len - 1)  return 2'b01;
    else                    return 2'b00;
  endfunction

  // One clock: observe at the falling edge, then return just after the rising edge.
  task automatic cycle();
    logic [DW-1:0] d;
    int            nrow;
    @(negedge clk);
    if (stalled) begin
      check("stall_wen", 32'(out_wen), 32'd1);
      check("stall_data", 32'(out_data), 32'(stall_data));
    end
    stalled    = out_wen && !out_ready;
    stall_data = out_data;
    if (done) done_cnt++;
    if (out_wen) wen_cnt++;
    if (in_valid && in_ready) begin
      acc_q.push_back(in_data);
      if (tx_q.size() > 0) void'(tx_q.pop_front());
    end
    if (out_wen && out_ready) begin
      nrow = m_R * m_L;
      if (m_k < nrow) begin
        if (acc_q.size() == 0) check("underrun", 32'd1, 32'd0);
        else begin
          d = acc_q.pop_front();
          check("row_word", 32'(out_data), 32'({exp_tag(m_k % m_L, m_L), d}));
        end
      end else if (m_k < nrow + m_F) begin
        check("flush_word", 32'(out_data), 32'({exp_tag(m_k - nrow, m_F), DW'(0)}));
      end else begin
        check("extra_word", 32'd1, 32'd0);
      end
      m_k++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int vp, input int rp);
    if (tx_q.size() > 0 && int'($urandom_range(99)) < vp) begin
      in_valid = 1'b1;
      in_data  = tx_q[0];
    end else begin
      in_valid = 1'b0;
      in_data  = DW'($urandom);
    end
    out_ready = (int'($urandom_range(99)) < rp);
  endtask

  task automatic set_frame(input int L, input int R, input int F, input bit seq);
    int need;
    need = R * L - acc_q.size() - tx_q.size();
    for (int i = 0; i < need; i++)
      tx_q.push_back(seq ? DW'(i + 1) : DW'($urandom));
    m_L = L; m_R = R; m_F = F; m_k = 0;
    done_cnt  = 0;
    row_len   = LW'(L);
    num_rows  = LW'(R);
    flush_len = LW'(F);
  endtask

  task automatic run_frame(input int L, input int R, input int F,
                           input int vp, input int rp, input bit seq);
    set_frame(L, R, F, seq);
    start = 1'b1;
    drive(vp, rp);
    cycle();
    start = 1'b0;
    check("busy_at_start", 32'(busy), 32'd1);
    check("err_cleared", 32'(err), 32'd0);
    for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
      drive(vp, rp);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    check("done_once", 32'(done_cnt), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
    check("words_out", 32'(m_k), 32'(R * L + F));
    check("fifo_drained", 32'(acc_q.size()), 32'd0);
  endtask

  task automatic idle_model();
    acc_q.delete();
    tx_q.delete();
    stalled = 1'b0;
    m_L = 0; m_R = 0; m_F = 0; m_k = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    row_len = '0; num_rows = '0; flush_len = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    stalled = 1'b0; stall_data = '0;
    m_L = 0; m_R = 0; m_F = 0; m_k = 0; done_cnt = 0; wen_cnt = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_wen", 32'(out_wen), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cycle();
    check("idle_no_start", 32'(busy), 32'd0);

    // Normal frame, words 1..6
    run_frame(3, 2, 0, 100, 100, 1'b1);
    // Flush row
    run_frame(12, 1, 5, 100, 100, 1'b0);
    // Single-word rows under light backpressure
    run_frame(1, 3, 0, 80, 70, 1'b0);
    // Explicit 1-0-0-1 stall pattern during a frame
    set_frame(4, 1, 2, 1'b0);
    start = 1'b1; drive(100, 100); cycle(); start = 1'b0;
    for (int c = 0; c < 200 && done_cnt == 0; c++) begin
      drive(100, 100);
      if (c >= 2 && c < 6) out_ready = (c == 2 || c == 5);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1; cycle(); cycle();
    check("bp_done", 32'(done_cnt), 32'd1);
    check("bp_words", 32'(m_k), 32'd6);

    // Fill FIFO while idle, then a dropped push, then frame the stored words
    for (int k = 0; k < int'(FD); k++) tx_q.push_back(DW'(16'h0100 + k));
    for (int k = 0; k < int'(FD); k++) begin drive(100, 0); cycle(); end
    in_valid = 1'b0;
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = DW'(16'hDEAD);
    cycle();
    in_valid = 1'b0;
    check("full_still", 32'(in_ready), 32'd0);
    check("full_held", 32'(acc_q.size()), 32'(FD));
    run_frame(int'(FD), 1, 0, 100, 100, 1'b0);

    // Illegal configurations: row_len==0, then num_rows==0
    for (int t = 0; t < 2; t++) begin
      idle_model();
      row_len   = (t == 0) ? LW'(0) : LW'(3);
      num_rows  = (t == 0) ? LW'(3) : LW'(0);
      flush_len = LW'(2);
      done_cnt = 0; wen_cnt = 0;
      out_ready = 1'b1;
      start = 1'b1;
      cycle();
      start = 1'b0;
      check("bad_err", 32'(err), 32'd1);
      check("bad_busy", 32'(busy), 32'd1);
      cycle(); cycle(); cycle();
      check("bad_done", 32'(done_cnt), 32'd1);
      check("bad_err_sticky", 32'(err), 32'd1);
      check("bad_busy_after", 32'(busy), 32'd0);
      check("bad_no_wen", 32'(wen_cnt), 32'd0);
    end
    run_frame(2, 2, 1, 90, 90, 1'b0);

    // Randomized frames
    for (int t = 0; t < 8; t++)
      run_frame(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
                int'($urandom_range(0, 4)), int'($urandom_range(30, 100)),
                int'($urandom_range(30, 100)), 1'b0);

    // Abort after the 2nd word, with a same-cycle start that must lose
    set_frame(4, 2, 0, 1'b0);
    start = 1'b1; drive(100, 100); cycle(); start = 1'b0;
    for (int c = 0; c < 100 && m_k < 2; c++) begin drive(100, 100); cycle(); end
    abort = 1'b1; start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    row_len = LW'(2); num_rows = LW'(1); flush_len = LW'(0);
    cycle();
    abort = 1'b0; start = 1'b0;
    idle_model();
    done_cnt = 0;
    check("abort_wen", 32'(out_wen), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_fifo_empty", 32'(in_ready), 32'd1);
    cycle(); cycle();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_frame(3, 2, 2, 80, 80, 1'b0);

    // Reset asserted mid-flush
    set_frame(2, 1, 8, 1'b0);
    start = 1'b1; drive(100, 100); cycle(); start = 1'b0;
    for (int c = 0; c < 100 && m_k < 3; c++) begin drive(100, 100); cycle(); end
    check("mid_flush_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("rr_out_wen", 32'(out_wen), 32'd0);
    check("rr_out_data", 32'(out_data), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_done", 32'(done), 32'd0);
    check("rr_err", 32'(err), 32'd0);
    check("rr_in_ready", 32'(in_ready), 32'd1);
    idle_model();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cycle(); cycle();
    check("rr_stay_idle", 32'(busy), 32'd0);
    run_frame(5, 2, 3, 70, 60, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifmap_stream_framer.md
IFMAP_STREAM_FRAMER -- requirements
Module: ifmap_stream_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the raw ifmap word width.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, the width of the row-length, row-count and flush-length fields.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the input FIFO depth (power of 2, at least 2).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit, a one-cycle pulse that latches the configuration and begins a frame.
REQ-007 SHALL have port abort, input, 1 bit, a synchronous frame cancel.
REQ-008 SHALL have port row_len, input, LEN_WIDTH bits, words per row.
REQ-009 SHALL have port num_rows, input, LEN_WIDTH bits, rows per frame.
REQ-010 SHALL have port flush_len, input, LEN_WIDTH bits, zero words appended after the last row (0 means no flush row).
REQ-011 SHALL have port in_data, input, DATA_WIDTH bits, the raw ifmap word.
REQ-012 SHALL have port in_valid, input, 1 bit, meaning in_data is valid.
REQ-013 SHALL have port in_ready, output, 1 bit, meaning the FIFO can accept a word.
REQ-014 SHALL have port out_data, output, DATA_WIDTH+2 bits, {tag[1:0], word}.
REQ-015 SHALL have port out_wen, output, 1 bit, write enable toward the IFmap buffer.
REQ-016 SHALL have port out_ready, input, 1 bit, the IFmap buffer ready.
REQ-017 SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-018 SHALL have port done, output, 1 bit, a one-cycle pulse at frame end.
REQ-019 SHALL have port err, output, 1 bit, sticky error for an illegal configuration, cleared by the next accepted start.

Function
REQ-020 SHALL accept an input word when in_valid and in_ready are both high on a clock edge; in_ready SHALL equal not-full and SHALL be independent of FSM state.
REQ-021 SHALL NOT accept a write while the FIFO is full, even when a pop occurs in the same cycle.
REQ-022 SHALL allow a simultaneous push and pop when the FIFO is not full; the count SHALL then be unchanged.
REQ-023 SHALL implement FSM states IDLE, ROW, FLUSH and END.
REQ-024 IDLE -> ROW on start when row_len>0 and num_rows>0; the configuration is latched on that edge.
REQ-025 SHALL, on start with row_len==0 or num_rows==0, go IDLE -> END, set err and emit no words.
REQ-026 SHALL ignore start while busy.
REQ-027 In ROW, each output word SHALL be a popped FIFO word.
REQ-028 Word count w (0..row_len-1) SHALL set the tag: 2'b10 when w==0, 2'b01 when w==row_len-1, 2'b11 when row_len==1, otherwise 2'b00.
REQ-029 SHALL move ROW -> FLUSH after the last word of row num_rows-1 transfers when flush_len>0, and ROW -> END otherwise.
REQ-030 In FLUSH, SHALL emit flush_len words with data 0, tagged per REQ-028 using flush_len as the row length; FLUSH -> END after the last transfer.
REQ-031 END SHALL last one cycle: done=1, then -> IDLE; busy SHALL be high in ROW, FLUSH and END.
REQ-032 SHALL hold out_data and out_wen in a register stage.
REQ-033 A word transfers when out_wen and out_ready are both high.
REQ-034 While out_wen is high and out_ready is low, out_data SHALL hold stable.
REQ-035 SHALL load the next word in the transfer cycle when one is available, giving one word per cycle sustained throughput.
REQ-036 Latency SHALL be 1 cycle from FIFO non-empty (in ROW) to out_wen high.
REQ-037 In ROW with the FIFO empty, out_wen SHALL drop after the transfer and the word counters SHALL hold.
REQ-038 Word and row counters SHALL be LEN_WIDTH bits, compare with equality and never wrap within a frame.
REQ-039 On abort (any state), SHALL clear the FIFO, counters and out_wen, and go to IDLE without a done pulse.
REQ-040 abort SHALL have priority over start in the same cycle.
REQ-041 SHALL leave FIFO contents untouched when idle, so words pushed before start are framed.

Reset
REQ-042 On reset low, SHALL asynchronously force: state IDLE, FIFO empty, in_ready=1, out_wen=0, out_data=0, busy=0, done=0, err=0, counters 0.
REQ-043 Reset asserted mid-frame SHALL discard all data.
REQ-044 After reset release, SHALL stay in IDLE until start.

Verification
REQ-045 Normal frame: row_len=3, num_rows=2, flush_len=0, push 1..6, out_ready=1 -> out_data tags 10,00,01,10,00,01 with words 1..6; done pulse once; busy low after.
REQ-046 Flush row: row_len=12, num_rows=1, flush_len=5 -> 12 tagged words, then 0x20000, 0, 0, 0, 0x10000; then done.
REQ-047 Backpressure: out_ready toggles 1-0-0-1 during a frame -> out_data stable while stalled, no word lost or duplicated; FIFO fill of FIFO_DEPTH drives in_ready=0, and a push attempt while full is dropped.
REQ-048 Single-word rows and illegal configuration: row_len=1, num_rows=3 -> three words tagged 11; row_len=0 -> err=1, done pulse, no out_wen.
REQ-049 Abort and reset: abort after the 2nd word -> out_wen=0 next cycle, FIFO empty, no done, a new start works; reset low mid-FLUSH -> all outputs at reset values immediately.
